// File: rtl/sisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sisc_pkg
// Description : Shared definitions for the SISC control sequencer:
//               sequencer state encoding, latched instruction class,
//               opcode values, alu_op encodings and status bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
package sisc_pkg;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_START0    = 4'd0,
        ST_START1    = 4'd1,
        ST_FETCH     = 4'd2,
        ST_DECODE    = 4'd3,
        ST_EXECUTE   = 4'd4,
        ST_MEM       = 4'd5,
        ST_WRITEBACK = 4'd6,
        ST_SWAP2     = 4'd7,
        ST_HALT      = 4'd8
    } state_e;

    // Instruction class captured at DECODE; it fixes the state path so a
    // later opcode change can only disturb strobes, never the sequence.
    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_LOD = 2'd1,
        CLS_STR = 2'd2,
        CLS_SWP = 2'd3
    } cls_e;

    // Opcodes
    localparam int OP_NOOP   = 0;
    localparam int OP_LOD    = 1;
    localparam int OP_STR    = 2;
    localparam int OP_SWP    = 3;
    localparam int OP_BRA    = 4;
    localparam int OP_BRR    = 5;
    localparam int OP_BNE    = 6;
    localparam int OP_BNR    = 7;
    localparam int OP_ALU    = 8;
    localparam int OP_ILL_LO = 9;
    localparam int OP_ILL_HI = 14;
    localparam int OP_HLT    = 15;

    // alu_op encodings
    localparam logic [1:0] ALU_RR   = 2'b00;
    localparam logic [1:0] ALU_RI   = 2'b01;
    localparam logic [1:0] ALU_ADDR = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    // Status register bit indices (C,N,V,Z from MSB)
    localparam int STAT_C = 3;
    localparam int STAT_N = 2;
    localparam int STAT_V = 1;
    localparam int STAT_Z = 0;

endpackage
`default_nettype wire

// File: rtl/sisc_br_eval.sv
`default_nettype none
// ============================================================================
// Module      : sisc_br_eval
// Description : Combinational branch evaluation. BRA/BRR are taken when any
//               masked status bit is set; BNE/BNR when none is. abs_tgt is
//               high for the absolute-target forms (BRA/BNE).
// Ports       : opcode (in)  instruction opcode
//               mm     (in)  condition mask
//               stat   (in)  status register
//               taken  (out) branch taken
//               abs_tgt(out) absolute (1) or PC-relative (0) target
// Revision    : 1.0 - initial release
// ============================================================================
module sisc_br_eval
    import sisc_pkg::*;
#(
    parameter int OPW   = 4,
    parameter int STATW = 4
) (
    input  logic [OPW-1:0]   opcode,
    input  logic [STATW-1:0] mm,
    input  logic [STATW-1:0] stat,
    output logic             taken,
    output logic             abs_tgt
);

    logic w_hit;
    assign w_hit = |(stat & mm);

    always_comb begin
        taken   = 1'b0;
        abs_tgt = 1'b0;
        case (opcode)
            OPW'(OP_BRA): begin taken = w_hit;  abs_tgt = 1'b1; end
            OPW'(OP_BRR): begin taken = w_hit;  abs_tgt = 1'b0; end
            OPW'(OP_BNE): begin taken = ~w_hit; abs_tgt = 1'b1; end
            OPW'(OP_BNR): begin taken = ~w_hit; abs_tgt = 1'b0; end
            default:      begin taken = 1'b0;   abs_tgt = 1'b0; end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sisc_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : sisc_ctrl_seq
// Description : Multicycle control sequencer for the SISC processor. Decodes
//               opcode/mm, steps a per-class state sequence and drives all
//               datapath strobes combinationally from the present state.
// Ports       : clk, rst_f (async active-low reset)
//               opcode, mm, stat           - instruction fields / status
//               rf_we, alu_op, wb_sel, swp_sel, stat_en, ir_load, pc_write,
//               pc_sel, br_sel, pc_rst, rb_sel, mm_sel, dm_we - strobes
//               halted, illegal            - sequencer status
// Config      : SISC_ILLEGAL_TRAP_EN - opcodes 9..14 trap to HALT with
//               illegal=1; when undefined they behave as NOOP.
// Revision    : 1.0 - initial release
// ============================================================================
module sisc_ctrl_seq
    import sisc_pkg::*;
#(
    parameter int OPW    = 4,
    parameter int MMW    = 4,
    parameter int STATW  = 4,
    parameter int AM_IMM = 8
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic [OPW-1:0]   opcode,
    input  logic [MMW-1:0]   mm,
    input  logic [STATW-1:0] stat,
    output logic             rf_we,
    output logic [1:0]       alu_op,
    output logic             wb_sel,
    output logic             swp_sel,
    output logic             stat_en,
    output logic             ir_load,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             br_sel,
    output logic             pc_rst,
    output logic             rb_sel,
    output logic             mm_sel,
    output logic             dm_we,
    output logic             halted,
    output logic             illegal
);

    state_e state_q, state_d;
    cls_e   cls_q,   cls_d;

    logic w_br_taken;
    logic w_br_abs;

    sisc_br_eval #(
        .OPW   (OPW),
        .STATW (STATW)
    ) u_br_eval (
        .opcode  (opcode),
        .mm      (mm),
        .stat    (stat),
        .taken   (w_br_taken),
        .abs_tgt (w_br_abs)
    );

    // ALU operation chosen in EXECUTE; WRITEBACK reuses it so the result
    // path stays stable while the register file is written.
    function automatic logic [1:0] f_exec_alu_op(input logic [OPW-1:0] op,
                                                 input logic [MMW-1:0] m);
        logic [1:0] r;
        r = ALU_RR;
        if (op == OPW'(OP_ALU))
            r = (m == MMW'(AM_IMM)) ? ALU_RI : ALU_RR;
        else if (op == OPW'(OP_LOD) || op == OPW'(OP_STR))
            r = ALU_ADDR;
        else if (op == OPW'(OP_SWP))
            r = ALU_PASS;
        return r;
    endfunction

`ifdef SISC_ILLEGAL_TRAP_EN
    logic ill_q, ill_d;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) ill_q <= 1'b0;
        else        ill_q <= ill_d;
    end

    assign illegal = ill_q;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= ST_START0;
            cls_q   <= CLS_ALU;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
`ifdef SISC_ILLEGAL_TRAP_EN
        ill_d    = ill_q;
`endif
        rf_we    = 1'b0;
        alu_op   = ALU_RR;
        wb_sel   = 1'b0;
        swp_sel  = 1'b0;
        stat_en  = 1'b0;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        pc_rst   = 1'b0;
        rb_sel   = 1'b0;
        mm_sel   = 1'b0;
        dm_we    = 1'b0;
        halted   = 1'b0;

        case (state_q)
            ST_START0: state_d = ST_START1;

            ST_START1: begin
                pc_rst  = 1'b1;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                pc_sel   = 1'b0;
                state_d  = ST_DECODE;
            end

            ST_DECODE: begin
                state_d = ST_FETCH;
                if (w_br_taken) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = w_br_abs;
                end
                case (opcode)
                    OPW'(OP_LOD): begin cls_d = CLS_LOD; state_d = ST_EXECUTE; end
                    OPW'(OP_STR): begin cls_d = CLS_STR; state_d = ST_EXECUTE; end
                    OPW'(OP_SWP): begin cls_d = CLS_SWP; state_d = ST_EXECUTE; end
                    OPW'(OP_ALU): begin cls_d = CLS_ALU; state_d = ST_EXECUTE; end
                    OPW'(OP_HLT): state_d = ST_HALT;
                    default: begin
`ifdef SISC_ILLEGAL_TRAP_EN
                        if (opcode >= OPW'(OP_ILL_LO) && opcode <= OPW'(OP_ILL_HI)) begin
                            state_d = ST_HALT;
                            ill_d   = 1'b1;
                        end
`endif
                    end
                endcase
            end

            ST_EXECUTE: begin
                alu_op  = f_exec_alu_op(opcode, mm);
                rb_sel  = (opcode == OPW'(OP_STR));
                state_d = (cls_q == CLS_LOD || cls_q == CLS_STR) ? ST_MEM : ST_WRITEBACK;
            end

            ST_MEM: begin
                alu_op = ALU_ADDR;
                mm_sel = 1'b1;
                if (opcode == OPW'(OP_STR)) begin
                    dm_we  = 1'b1;
                    rb_sel = 1'b1;
                end
                state_d = (cls_q == CLS_LOD) ? ST_WRITEBACK : ST_FETCH;
            end

            ST_WRITEBACK: begin
                rf_we   = 1'b1;
                alu_op  = f_exec_alu_op(opcode, mm);
                wb_sel  = (opcode == OPW'(OP_LOD));
                stat_en = (opcode == OPW'(OP_ALU));
                state_d = (cls_q == CLS_SWP) ? ST_SWAP2 : ST_FETCH;
            end

            ST_SWAP2: begin
                rf_we   = 1'b1;
                swp_sel = 1'b1;
                alu_op  = ALU_PASS;
                state_d = ST_FETCH;
            end

            ST_HALT: begin
                halted  = 1'b1;
                state_d = ST_HALT;
            end

            default: state_d = ST_START0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sisc_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sisc_ctrl_seq
// Description : Self-checking bench for sisc_ctrl_seq. Directed table of
//               instructions with per-cycle expected strobes, hand-written
//               halt/reset/illegal sequences, then random instructions
//               checked against a per-instruction strobe model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sisc_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_f = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic [3:0] mm = 4'd0;
    logic [3:0] stat = 4'd0;

    logic       rf_we, wb_sel, swp_sel, stat_en, ir_load, pc_write, pc_sel;
    logic       br_sel, pc_rst, rb_sel, mm_sel, dm_we, halted, illegal;
    logic [1:0] alu_op;

    int n_tests = 0;
    int n_fail  = 0;

    sisc_ctrl_seq #(
        .OPW    (4),
        .MMW    (4),
        .STATW  (4),
        .AM_IMM (8)
    ) dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .rf_we    (rf_we),
        .alu_op   (alu_op),
        .wb_sel   (wb_sel),
        .swp_sel  (swp_sel),
        .stat_en  (stat_en),
        .ir_load  (ir_load),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .pc_rst   (pc_rst),
        .rb_sel   (rb_sel),
        .mm_sel   (mm_sel),
        .dm_we    (dm_we),
        .halted   (halted),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Output word: one bit per strobe, alu_op as a 2-bit field
    logic [15:0] got;
    assign got = {rf_we, alu_op, wb_sel, swp_sel, stat_en, ir_load, pc_write,
                  pc_sel, br_sel, pc_rst, rb_sel, mm_sel, dm_we, halted, illegal};

    localparam logic [15:0] RF     = 16'h8000;
    localparam logic [15:0] A_RI   = 16'h2000;
    localparam logic [15:0] A_ADDR = 16'h4000;
    localparam logic [15:0] A_PASS = 16'h6000;
    localparam logic [15:0] WB     = 16'h1000;
    localparam logic [15:0] SW     = 16'h0800;
    localparam logic [15:0] SE     = 16'h0400;
    localparam logic [15:0] IRL    = 16'h0200;
    localparam logic [15:0] PCW    = 16'h0100;
    localparam logic [15:0] PCS    = 16'h0080;
    localparam logic [15:0] BRS    = 16'h0040;
    localparam logic [15:0] PCR    = 16'h0020;
    localparam logic [15:0] RB     = 16'h0010;
    localparam logic [15:0] MMS    = 16'h0008;
    localparam logic [15:0] DMW    = 16'h0004;
    localparam logic [15:0] HLTD   = 16'h0002;
    localparam logic [15:0] ILL    = 16'h0001;
    localparam logic [15:0] F      = IRL | PCW;

    typedef struct packed {
        logic [3:0]       op;
        logic [3:0]       mm;
        logic [3:0]       stat;
        logic [2:0]       len;
        logic [4:0][15:0] w;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mkv(input logic [3:0] op, input logic [3:0] m,
                                 input logic [3:0] s, input int len,
                                 input logic [15:0] w0, input logic [15:0] w1,
                                 input logic [15:0] w2, input logic [15:0] w3,
                                 input logic [15:0] w4);
        vec_t v;
        v.op = op; v.mm = m; v.stat = s; v.len = 3'(len);
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
        return v;
    endfunction

    // Per-instruction strobe list from FETCH onward, straight from the
    // instruction-class rules.
    function automatic vec_t model(input logic [3:0] op, input logic [3:0] m,
                                   input logic [3:0] s);
        logic [15:0] a;
        bit taken;
        int o;
        o = int'(op);
        taken = 1'b0;
        if (o == 4 || o == 5) taken = ((s & m) != 4'd0);
        if (o == 6 || o == 7) taken = ((s & m) == 4'd0);
        if (o == 1) return mkv(op, m, s, 5, F, 0, A_ADDR, A_ADDR | MMS, RF | WB | A_ADDR);
        if (o == 2) return mkv(op, m, s, 4, F, 0, A_ADDR | RB, A_ADDR | MMS | DMW | RB, 0);
        if (o == 3) return mkv(op, m, s, 5, F, 0, A_PASS, RF | A_PASS, RF | SW | A_PASS);
        if (o == 8) begin
            a = (m == 4'd8) ? A_RI : 16'h0000;
            return mkv(op, m, s, 4, F, 0, a, RF | SE | a, 0);
        end
        if (taken)
            return mkv(op, m, s, 2, F, PCW | PCS | ((o == 4 || o == 6) ? BRS : 16'h0), 0, 0, 0);
        return mkv(op, m, s, 2, F, 0, 0, 0, 0);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Assert reset, release it, and leave the bench just inside FETCH.
    task automatic do_reset();
        rst_f = 1'b0;
        #1;
        check("reset_async", got, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_held", got, 16'h0000);
        rst_f = 1'b1;
        #1;
        check("start0", got, 16'h0000);
        @(posedge clk); #1;
        check("start1", got, PCR);
        @(posedge clk); #1;
    endtask

    // Entered just after the edge that starts FETCH; leaves just after the
    // edge following the last listed cycle.
    task automatic run_instr(input vec_t v, input bit rnd_stat);
        for (int k = 0; k < int'(v.len); k++) begin
            if (k == 0) begin
                opcode = v.op;
                mm     = v.mm;
            end
            stat = (rnd_stat && k != 1) ? 4'($urandom) : v.stat;
            @(negedge clk);
            check($sformatf("op%0d_mm%h_st%h_cyc%0d", v.op, v.mm, v.stat, k), got, v.w[k]);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] rop, rmm, rst;

        tbl[0]  = mkv(4'd0, 4'h0, 4'h0, 2, F, 0, 0, 0, 0);
        tbl[1]  = mkv(4'd8, 4'h8, 4'h0, 4, F, 0, A_RI, RF | SE | A_RI, 0);
        tbl[2]  = mkv(4'd8, 4'h0, 4'h0, 4, F, 0, 0, RF | SE, 0);
        tbl[3]  = mkv(4'd1, 4'h3, 4'h0, 5, F, 0, A_ADDR, A_ADDR | MMS, RF | WB | A_ADDR);
        tbl[4]  = mkv(4'd2, 4'h3, 4'h0, 4, F, 0, A_ADDR | RB, A_ADDR | MMS | DMW | RB, 0);
        tbl[5]  = mkv(4'd4, 4'h1, 4'h1, 2, F, PCW | PCS | BRS, 0, 0, 0);
        tbl[6]  = mkv(4'd4, 4'h1, 4'h0, 2, F, 0, 0, 0, 0);
        tbl[7]  = mkv(4'd7, 4'h1, 4'h0, 2, F, PCW | PCS, 0, 0, 0);
        tbl[8]  = mkv(4'd5, 4'h0, 4'hF, 2, F, 0, 0, 0, 0);
        tbl[9]  = mkv(4'd6, 4'h0, 4'hF, 2, F, PCW | PCS | BRS, 0, 0, 0);
        tbl[10] = mkv(4'd3, 4'h0, 4'h0, 5, F, 0, A_PASS, RF | A_PASS, RF | SW | A_PASS);
        tbl[11] = mkv(4'd6, 4'hC, 4'h4, 2, F, 0, 0, 0, 0);

        #3;
        do_reset();
        for (int i = 0; i < 12; i++) run_instr(tbl[i], 1'b0);

        // HLT parks the sequencer until reset
        run_instr(mkv(4'd15, 4'h0, 4'h0, 2, F, 0, 0, 0, 0), 1'b0);
        for (int i = 0; i < 10; i++) begin
            stat = 4'($urandom);
            @(negedge clk);
            check($sformatf("halt_hold%0d", i), got, HLTD);
            @(posedge clk); #1;
        end
        do_reset();

        // Reset in the MEM cycle of a store drops dm_we immediately
        run_instr(mkv(4'd2, 4'h5, 4'h0, 3, F, 0, A_ADDR | RB, 0, 0), 1'b0);
        @(negedge clk);
        check("str_mem_before_rst", got, A_ADDR | MMS | DMW | RB);
        do_reset();

        // Opcode 12: trap or NOOP depending on build
`ifdef SISC_ILLEGAL_TRAP_EN
        run_instr(mkv(4'd12, 4'h3, 4'h5, 2, F, 0, 0, 0, 0), 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("illegal_halt%0d", i), got, HLTD | ILL);
            @(posedge clk); #1;
        end
        do_reset();
`else
        run_instr(mkv(4'd12, 4'h3, 4'h5, 2, F, 0, 0, 0, 0), 1'b0);
`endif

        // Random instruction stream, stat scrambled outside DECODE
        for (int n = 0; n < 300; n++) begin
            rop = 4'($urandom_range(0, 14));
`ifdef SISC_ILLEGAL_TRAP_EN
            if (rop >= 4'd9) rop = rop - 4'd9;
`endif
            rmm = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom);
            rst = 4'($urandom);
            run_instr(model(rop, rmm, rst), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
